// File: rtl/pwm_diff_dac.sv
// Differential sign/magnitude PWM DAC fed by a small sample FIFO; one sample plays per 2^(WIDTH-1)-clock frame.
// Define PWM_DIFF_DAC_DEADTIME_EN to insert DEADTIME idle clocks at the start of a frame whose sign flips.
module pwm_diff_dac #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int DEADTIME = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    pwm_pos,
  output logic                    pwm_neg,
  output logic                    frame_start,
  output logic                    underrun
);
  localparam int CW = WIDTH - 1;
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);

  // Handshake: a sample transfers on a rising edge where sample_valid and sample_ready are both 1.
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [NW-1:0]           count_q, count_d;
  logic signed [WIDTH-1:0] mem_q [DEPTH];
  logic signed [WIDTH-1:0] active_q, active_d;
  logic                    ready_q, pos_q, neg_q, fs_q, ur_q;
  logic                    wrap, fifo_empty, push, pop;
  logic [WIDTH-1:0]        neg_val;
  logic [CW-1:0]           mag_d;
  logic                    on_d, gate_d;

  assign wrap       = &cnt_q;
  assign fifo_empty = (count_q == '0);
  assign push       = sample_valid && ready_q;
  assign pop        = wrap && !fifo_empty;
  assign cnt_d      = cnt_q + CW'(1);
  assign count_d    = count_q + NW'(push) - NW'(pop);
  assign active_d   = wrap ? (pop ? mem_q[rd_ptr_q] : '0) : active_q;
  assign neg_val    = -active_d;

  // The most negative sample has no positive twin, so it saturates to a full frame minus one.
  always_comb begin
    mag_d = active_d[CW-1:0];
    if (active_d[WIDTH-1]) begin
      if (active_d[CW-1:0] == '0) mag_d = '1;
      else                        mag_d = neg_val[CW-1:0];
    end
  end

  assign on_d = (cnt_d < mag_d);

`ifdef PWM_DIFF_DAC_DEADTIME_EN
  logic prev_nz_q, prev_neg_q, dt_frame_q;
  logic prev_nz_n, prev_neg_n, dt_frame_d;

  // The sign memory follows the last frame that actually drove a bridge.
  always_comb begin
    prev_nz_n  = prev_nz_q;
    prev_neg_n = prev_neg_q;
    if (active_q != '0) begin
      prev_nz_n  = 1'b1;
      prev_neg_n = active_q[WIDTH-1];
    end
    dt_frame_d = dt_frame_q;
    if (wrap) dt_frame_d = (active_d != '0) && prev_nz_n && (prev_neg_n != active_d[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_nz_q  <= 1'b0;
      prev_neg_q <= 1'b0;
      dt_frame_q <= 1'b0;
    end else begin
      if (wrap) begin
        prev_nz_q  <= prev_nz_n;
        prev_neg_q <= prev_neg_n;
      end
      dt_frame_q <= dt_frame_d;
    end
  end

  assign gate_d = dt_frame_d && (int'(cnt_d) < DEADTIME);
`else
  assign gate_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sample_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      active_q <= '0;
      ready_q  <= 1'b1;
      pos_q    <= 1'b0;
      neg_q    <= 1'b0;
      fs_q     <= 1'b0;
      ur_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_d;
      active_q <= active_d;
      ready_q  <= (count_d != NW'(DEPTH));
      fs_q     <= wrap;
      ur_q     <= wrap && fifo_empty;
      pos_q    <= on_d && !active_d[WIDTH-1] && !gate_d;
      neg_q    <= on_d &&  active_d[WIDTH-1] && !gate_d;
    end
  end

  assign sample_ready = ready_q;
  assign pwm_pos      = pos_q;
  assign pwm_neg      = neg_q;
  assign frame_start  = fs_q;
  assign underrun     = ur_q;
endmodule
